lcd_spi_write: RTL and testbench

LCD_SPI_WRITE -- requirements
Module: lcd_spi_write

---
 rtl/lcd_pkg.sv | 17 +
 rtl/lcd_spi_write_if.sv | 24 ++
 rtl/lcd_spi_tick.sv | 29 ++
 rtl/lcd_spi_write.sv | 141 ++++++++++++++
 tb/tb_lcd_spi_write.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD SPI word writer: FSM encoding, word layout
// and timing constants.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_DONE    = 2'd2,
    ST_RECOVER = 2'd3
  } lcd_state_e;

  localparam int LCD_WORD_W       = 9;
  localparam int LCD_DC_BIT       = 8;
  localparam int LCD_HALF_PER_DEF = 2;
  localparam int LCD_RECOVER_LEN  = 3;

endpackage

// File: rtl/lcd_spi_write_if.sv
// Upstream sequencer handshake plus the four-wire LCD SPI pins.
interface lcd_spi_write_if;
  import lcd_pkg::*;

  logic                  en_write;
  logic [LCD_WORD_W-1:0] init_data;
  logic                  wr_done;
  logic                  busy;
  logic                  lcd_cs;
  logic                  lcd_dc;
  logic                  lcd_sck;
  logic                  lcd_mosi;

  modport master (
    output en_write, init_data,
    input  wr_done, busy, lcd_cs, lcd_dc, lcd_sck, lcd_mosi
  );

  modport slave (
    input  en_write, init_data,
    output wr_done, busy, lcd_cs, lcd_dc, lcd_sck, lcd_mosi
  );

endinterface

// File: rtl/lcd_spi_tick.sv
// Half-period tick generator: one-cycle tick every HALF_PER clocks,
// restarted from zero by clr.
module lcd_spi_tick #(
  parameter int HALF_PER = 2
) (
  input  logic sys_clk_50MHz,
  input  logic sys_rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (HALF_PER < 2) ? 1 : $clog2(HALF_PER + 1);
  localparam logic [CNT_W-1:0] TC = CNT_W'(HALF_PER - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lcd_spi_write.sv
// Serialises one 9-bit D/C + payload word onto a mode-0 SPI LCD link per
// en_write request, then holds off for a short recovery window.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for en_write; CS high, SCK low
// ST_SHIFT   | CS low; setup half-period then 8 bit periods, MSB first
// ST_DONE    | single cycle: CS released, wr_done pulsed
// ST_RECOVER | fixed gap letting the upstream sequencer advance its word
module lcd_spi_write
  import lcd_pkg::*;
#(
  parameter int HALF_PER = LCD_HALF_PER_DEF
) (
  input  logic            sys_clk_50MHz,
  input  logic            sys_rst,
  lcd_spi_write_if.slave  bus
);

  lcd_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       setup_q, setup_d;
  logic [6:0] shreg_q, shreg_d;
  logic       cs_q, cs_d;
  logic       dc_q, dc_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       wr_done_q, wr_done_d;
  logic       tick;
  logic       tick_clr;

  // Tick phase restarts on every state change so each phase is a full HALF_PER.
  assign tick_clr = (state_d != state_q);

  lcd_spi_tick #(.HALF_PER(HALF_PER)) u_tick (
    .sys_clk_50MHz (sys_clk_50MHz),
    .sys_rst       (sys_rst),
    .clr           (tick_clr),
    .tick          (tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    setup_d   = setup_q;
    shreg_d   = shreg_q;
    cs_d      = cs_q;
    dc_d      = dc_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    wr_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.en_write) begin
          state_d   = ST_SHIFT;
          shreg_d   = bus.init_data[6:0];
          dc_d      = bus.init_data[LCD_DC_BIT];
          mosi_d    = bus.init_data[7];
          cs_d      = 1'b0;
          sck_d     = 1'b0;
          setup_d   = 1'b1;
          bit_cnt_d = '0;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          if (setup_q) begin
            setup_d = 1'b0;
            sck_d   = 1'b1;
          end else if (sck_q) begin
            sck_d = 1'b0;
            // Bit 0 stays on MOSI through its low phase as the CS hold time.
            if (bit_cnt_q != 3'd7) begin
              mosi_d  = shreg_q[6];
              shreg_d = {shreg_q[5:0], 1'b0};
            end
          end else if (bit_cnt_q == 3'd7) begin
            state_d   = ST_DONE;
            cs_d      = 1'b1;
            wr_done_d = 1'b1;
            bit_cnt_d = '0;
          end else begin
            sck_d     = 1'b1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      ST_DONE: begin
        state_d   = ST_RECOVER;
        bit_cnt_d = '0;
      end

      ST_RECOVER: begin
        // The bit counter doubles as the recovery timer; en_write is ignored here.
        if (bit_cnt_q == 3'(LCD_RECOVER_LEN - 1)) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      setup_q   <= 1'b0;
      shreg_q   <= '0;
      cs_q      <= 1'b1;
      dc_q      <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      setup_q   <= setup_d;
      shreg_q   <= shreg_d;
      cs_q      <= cs_d;
      dc_q      <= dc_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      wr_done_q <= wr_done_d;
    end
  end

  assign bus.lcd_cs   = cs_q;
  assign bus.lcd_dc   = dc_q;
  assign bus.lcd_sck  = sck_q;
  assign bus.lcd_mosi = mosi_q;
  assign bus.wr_done  = wr_done_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_spi_write.sv
// Bench for lcd_spi_write: two instances (HALF_PER 2 and 1) checked cycle by
// cycle against a waveform model derived from the frame timing rules.
module tb_lcd_spi_write;

  logic clk;
  logic rst0, rst1;
  int   checks = 0;
  int   errors = 0;
  int   sel_v  = 0;

  lcd_spi_write_if if0 ();
  lcd_spi_write_if if1 ();

  lcd_spi_write #(.HALF_PER(2)) dut0 (
    .sys_clk_50MHz (clk),
    .sys_rst       (rst0),
    .bus           (if0)
  );

  lcd_spi_write #(.HALF_PER(1)) dut1 (
    .sys_clk_50MHz (clk),
    .sys_rst       (rst1),
    .bus           (if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  logic s_cs, s_sck, s_mosi, s_dc, s_done, s_busy;
  always_comb begin
    if (sel_v == 1) begin
      s_cs = if1.lcd_cs;  s_sck = if1.lcd_sck;  s_mosi = if1.lcd_mosi;
      s_dc = if1.lcd_dc;  s_done = if1.wr_done; s_busy = if1.busy;
    end else begin
      s_cs = if0.lcd_cs;  s_sck = if0.lcd_sck;  s_mosi = if0.lcd_mosi;
      s_dc = if0.lcd_dc;  s_done = if0.wr_done; s_busy = if0.busy;
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic drive(input int sel, input logic en, input logic [8:0] d);
    if (sel == 1) begin
      if1.en_write = en; if1.init_data = d;
    end else begin
      if0.en_write = en; if0.init_data = d;
    end
  endtask

  // One word: request, then compare every cycle from accept through the
  // first idle cycle against the timing model.
  task automatic frame(input int sel, input logic [8:0] w, input int drop_k,
                       input bit rel_rst, output logic [7:0] bits,
                       output int lat, output int rises, output logic dc_seen);
    int   h;
    int   m;
    logic prev_sck;
    logic e_cs, e_sck, e_done, e_busy;
    h = (sel == 1) ? 1 : 2;
    bits = '0; lat = -1; rises = 0; prev_sck = 1'b0; dc_seen = 1'bx;
    @(negedge clk);
    sel_v = sel;
    if (rel_rst) rst0 = 1'b0;
    drive(sel, 1'b1, w);
    @(posedge clk);
    for (int k = 0; k <= 17*h + 4; k++) begin
      @(negedge clk);
      if (k >= drop_k) drive(sel, 1'b0, 9'($urandom));
      e_cs   = !(k < 17*h);
      e_sck  = (k < 17*h) && ((k / h) % 2 == 1);
      e_done = (k == 17*h);
      e_busy = (k <= 17*h + 3);
      chk1($sformatf("cs w=%h k=%0d", w, k), s_cs, e_cs);
      chk1($sformatf("sck w=%h k=%0d", w, k), s_sck, e_sck);
      chk1($sformatf("wr_done w=%h k=%0d", w, k), s_done, e_done);
      chk1($sformatf("busy w=%h k=%0d", w, k), s_busy, e_busy);
      if (k < 17*h) begin
        m = k / (2*h);
        if (m > 7) m = 7;
        chk1($sformatf("mosi w=%h k=%0d", w, k), s_mosi, w[7-m]);
      end
      if (k <= 17*h + 3)
        chk1($sformatf("dc w=%h k=%0d", w, k), s_dc, w[8]);
      if (k == 0) dc_seen = s_dc;
      if (!s_cs && s_sck && !prev_sck) begin
        bits = {bits[6:0], s_mosi};
        rises++;
      end
      prev_sck = s_sck;
      if (s_done && lat < 0) lat = k;
    end
    drive(sel, 1'b0, 9'h000);
  endtask

  typedef struct {
    int         sel;
    logic [8:0] word;
    int         drop;
    logic       exp_dc;
    logic [7:0] exp_bits;
    int         exp_lat;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] bits;
  int         lat, rises, nd;
  logic       dcs;

  initial begin
    vecs[0] = '{0, 9'h011, 0, 1'b0, 8'b0001_0001, 34};
    vecs[1] = '{0, 9'h1A5, 0, 1'b1, 8'b1010_0101, 34};
    vecs[2] = '{0, 9'h136, 5, 1'b1, 8'b0011_0110, 34};
    vecs[3] = '{1, 9'h0b2, 0, 1'b0, 8'b1011_0010, 17};
    vecs[4] = '{0, 9'h100, 0, 1'b1, 8'b0000_0000, 34};
    vecs[5] = '{1, 9'h0ff, 40, 1'b0, 8'b1111_1111, 17};

    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b1, 9'h1ff);
    drive(1, 1'b1, 9'h1ff);
    repeat (3) @(negedge clk);
    chk1("rst0 cs", if0.lcd_cs, 1'b1);     chk1("rst1 cs", if1.lcd_cs, 1'b1);
    chk1("rst0 sck", if0.lcd_sck, 1'b0);   chk1("rst1 sck", if1.lcd_sck, 1'b0);
    chk1("rst0 mosi", if0.lcd_mosi, 1'b0); chk1("rst1 mosi", if1.lcd_mosi, 1'b0);
    chk1("rst0 dc", if0.lcd_dc, 1'b0);     chk1("rst1 dc", if1.lcd_dc, 1'b0);
    chk1("rst0 done", if0.wr_done, 1'b0);  chk1("rst1 done", if1.wr_done, 1'b0);
    chk1("rst0 busy", if0.busy, 1'b0);     chk1("rst1 busy", if1.busy, 1'b0);
    drive(0, 1'b0, 9'h000);
    drive(1, 1'b0, 9'h000);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      frame(vecs[i].sel, vecs[i].word, vecs[i].drop, 1'b0, bits, lat, rises, dcs);
      chki($sformatf("vec%0d bits", i), int'(bits), int'(vecs[i].exp_bits));
      chki($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      chki($sformatf("vec%0d rises", i), rises, 8);
      chk1($sformatf("vec%0d dc", i), dcs, vecs[i].exp_dc);
    end

    for (int i = 0; i < 12; i++) begin
      int         sel;
      logic [8:0] w;
      sel = int'($urandom_range(0, 1));
      w   = 9'($urandom);
      frame(sel, w, int'($urandom_range(0, 40)), 1'b0, bits, lat, rises, dcs);
      chki($sformatf("rnd%0d bits", i), int'(bits), int'(w[7:0]));
      chki($sformatf("rnd%0d latency", i), lat, 17 * ((sel == 1) ? 1 : 2));
      chki($sformatf("rnd%0d rises", i), rises, 8);
    end

    // Back-to-back words with en_write held and an upstream that advances
    // its word two cycles after each wr_done.
    begin
      logic [8:0] words [3];
      int         adv_at, ndone, gap, idx;
      logic [7:0] sh;
      logic       dcl, prev_sck, prev_cs;
      words[0] = 9'h02a; words[1] = 9'h100; words[2] = 9'h1ef;
      adv_at = -1; ndone = 0; gap = 0; idx = 0;
      sh = '0; dcl = 1'b0; prev_sck = 1'b0; prev_cs = 1'b1;
      sel_v = 0;
      @(negedge clk);
      drive(0, 1'b1, words[0]);
      for (int c = 0; c < 400 && ndone < 3; c++) begin
        @(negedge clk);
        if (c == adv_at) begin
          idx++;
          drive(0, 1'b1, words[idx]);
        end
        if (!s_cs && s_sck && !prev_sck) sh = {sh[6:0], s_mosi};
        if (!s_cs) dcl = s_dc;
        if (s_cs && s_busy && !s_done) gap++;
        if (!s_cs && prev_cs && ndone > 0)
          chki($sformatf("b2b gap before frame %0d", ndone), gap, 3);
        prev_sck = s_sck;
        prev_cs  = s_cs;
        if (s_done) begin
          chki($sformatf("b2b word %0d", ndone), int'({dcl, sh}), int'(words[ndone]));
          ndone++;
          gap = 0;
          if (ndone < 3) adv_at = c + 2;
          else           drive(0, 1'b0, 9'h000);
        end
      end
      chki("b2b frames completed", ndone, 3);
      drive(0, 1'b0, 9'h000);
      nd = 0;
      repeat (40) begin
        @(negedge clk);
        if (s_done) nd++;
      end
      chki("b2b no extra frame", nd, 0);
    end

    // Reset during the high phase of the fourth bit (data bit 4) of 9'h0ff.
    sel_v = 0;
    nd = 0;
    @(negedge clk);
    drive(0, 1'b1, 9'h0ff);
    @(posedge clk);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      drive(0, 1'b0, 9'h000);
      if (s_done) nd++;
      if (k == 14) begin
        chk1("rst_mid sck high before reset", s_sck, 1'b1);
        rst0 = 1'b1;
      end
    end
    @(negedge clk);
    if (s_done) nd++;
    chk1("rst_mid cs", s_cs, 1'b1);
    chk1("rst_mid sck", s_sck, 1'b0);
    chk1("rst_mid mosi", s_mosi, 1'b0);
    chk1("rst_mid busy", s_busy, 1'b0);
    chki("rst_mid no wr_done", nd, 0);
    frame(0, 9'h029, 0, 1'b1, bits, lat, rises, dcs);
    chki("post_rst bits", int'(bits), 8'h29);
    chki("post_rst latency", lat, 34);
    chki("post_rst rises", rises, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
